// File: rtl/sign_narrower_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : sign_narrower_pipe_if
// Description : Upstream/downstream handshake and data bundle for the
//               N-to-M signed narrowing pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface sign_narrower_pipe_if #(
    parameter int N = 32,
    parameter int M = 16
);
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_data;
    logic         o_valid;
    logic         i_ready;
    logic [M-1:0] o_data;
    logic         o_ovf;

    // The narrowing block is the slave; the surrounding logic is the master.
    modport slave (
        input  i_valid,
        input  i_data,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_data,
        output o_ovf
    );

    modport master (
        output i_valid,
        output i_data,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_data,
        input  o_ovf
    );
endinterface
`default_nettype wire

// File: rtl/sign_narrower_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sign_narrower_pipe
// Description : Two-stage N-to-M bit signed narrowing with overflow flag and
//               saturating overflow counter. Define SIGN_NARROWER_SAT_EN to
//               saturate overflowed beats instead of wrapping them.
// Revision    : 1.0 - initial release
// ============================================================================
module sign_narrower_pipe #(
    parameter int N     = 32,
    parameter int M     = 16,
    parameter int CNT_W = 16
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    sign_narrower_pipe_if.slave   bus,
    input  wire logic             i_clr_cnt,
    output logic [CNT_W-1:0]      o_ovf_cnt
);

`ifdef SIGN_NARROWER_SAT_EN
    localparam logic [M-1:0] C_SAT_MAX = {1'b0, {(M-1){1'b1}}};
    localparam logic [M-1:0] C_SAT_MIN = {1'b1, {(M-1){1'b0}}};
`endif

    logic             s1_valid_q, s1_valid_d;
    logic [M-1:0]     s1_data_q,  s1_data_d;
    logic             s1_ovf_q,   s1_ovf_d;
    logic             s2_valid_q, s2_valid_d;
    logic [M-1:0]     s2_data_q,  s2_data_d;
    logic             s2_ovf_q,   s2_ovf_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic             in_fit;
    logic [M-1:0]     in_narrow;
    logic             s2_xfer;
    logic             s1_adv;
    logic             in_accept;
    logic             ovf_xfer;

    // Fits iff every bit from the top down to the new sign bit matches.
    always_comb begin
        in_fit = (&bus.i_data[N-1:M-1]) | ~(|bus.i_data[N-1:M-1]);
`ifdef SIGN_NARROWER_SAT_EN
        if (in_fit)
            in_narrow = bus.i_data[M-1:0];
        else
            in_narrow = bus.i_data[N-1] ? C_SAT_MIN : C_SAT_MAX;
`else
        in_narrow = bus.i_data[M-1:0];
`endif
    end

    assign s2_xfer     = s2_valid_q & bus.i_ready;
    assign s1_adv      = s1_valid_q & (~s2_valid_q | bus.i_ready);
    assign bus.o_ready = ~s1_valid_q | s1_adv;
    assign in_accept   = bus.i_valid & bus.o_ready;
    assign ovf_xfer    = s2_xfer & s2_ovf_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_ovf_d   = s1_ovf_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_ovf_d   = s2_ovf_q;
        cnt_d      = cnt_q;

        if (in_accept) begin
            s1_valid_d = 1'b1;
            s1_data_d  = in_narrow;
            s1_ovf_d   = ~in_fit;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // S2 keeps its last data when it drains so o_data only moves on a load.
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_data_d  = s1_data_q;
            s2_ovf_d   = s1_ovf_q;
        end else if (s2_xfer) begin
            s2_valid_d = 1'b0;
        end

        if (i_clr_cnt)
            cnt_d = ovf_xfer ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
        else if (ovf_xfer && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_ovf_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_ovf_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_ovf_q   <= s1_ovf_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_ovf_q   <= s2_ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.o_valid = s2_valid_q;
    assign bus.o_data  = s2_data_q;
    assign bus.o_ovf   = s2_ovf_q;
    assign o_ovf_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sign_narrower_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sign_narrower_pipe
// Description : Directed-vector bench for sign_narrower_pipe (N=32, M=16),
//               with a CNT_W=4 twin instance for counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sign_narrower_pipe;

    logic        clk;
    logic        rst_n;
    logic        clr_cnt;
    logic [15:0] ovf_cnt;
    logic [3:0]  ovf_cnt4;
    int          n_checks;
    int          n_pass;

    sign_narrower_pipe_if #(.N(32), .M(16)) bus  ();
    sign_narrower_pipe_if #(.N(32), .M(16)) bus4 ();

    sign_narrower_pipe #(.N(32), .M(16), .CNT_W(16)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .bus       (bus.slave),
        .i_clr_cnt (clr_cnt),
        .o_ovf_cnt (ovf_cnt)
    );

    sign_narrower_pipe #(.N(32), .M(16), .CNT_W(4)) dut4 (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .bus       (bus4.slave),
        .i_clr_cnt (clr_cnt),
        .o_ovf_cnt (ovf_cnt4)
    );

    assign bus4.i_valid = bus.i_valid;
    assign bus4.i_data  = bus.i_data;
    assign bus4.i_ready = bus.i_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [15:0] exp_wrap;
        logic [15:0] exp_sat;
        logic        exp_ovf;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] exp_data(input vec_t v);
`ifdef SIGN_NARROWER_SAT_EN
        return v.exp_sat;
`else
        return v.exp_wrap;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n copies of d with the sink always ready, then drains.
    task automatic send_stream(input logic [31:0] d, input int n);
        bus.i_ready = 1'b1;
        bus.i_data  = d;
        bus.i_valid = 1'b1;
        for (int k = 0; k < n; k++) tick();
        bus.i_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int next_in;
        int exp_out;
        logic xfer;
        logic acc;

        n_checks = 0;
        n_pass   = 0;
        vecs[0] = '{32'h00007FFF, 16'h7FFF, 16'h7FFF, 1'b0};
        vecs[1] = '{32'hFFFF8000, 16'h8000, 16'h8000, 1'b0};
        vecs[2] = '{32'h00000000, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[4] = '{32'h00001234, 16'h1234, 16'h1234, 1'b0};
        vecs[5] = '{32'h00008000, 16'h8000, 16'h7FFF, 1'b1};
        vecs[6] = '{32'hFFFF7FFF, 16'h7FFF, 16'h8000, 1'b1};
        vecs[7] = '{32'h80000000, 16'h0000, 16'h8000, 1'b1};
        vecs[8] = '{32'h7FFFFFFF, 16'hFFFF, 16'h7FFF, 1'b1};
        vecs[9] = '{32'h12345678, 16'h5678, 16'h7FFF, 1'b1};

        rst_n       = 1'b0;
        clr_cnt     = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_data  = '0;
        #1;
        check("rst_o_valid", {31'b0, bus.o_valid}, 32'd0);
        check("rst_o_data",  {16'b0, bus.o_data},  32'd0);
        check("rst_o_ovf",   {31'b0, bus.o_ovf},   32'd0);
        check("rst_cnt",     {16'b0, ovf_cnt},     32'd0);
        check("rst_o_ready", {31'b0, bus.o_ready}, 32'd1);
        #20 rst_n = 1'b1;
        tick();

        // Back-to-back vector stream: each result appears two edges after drive.
        bus.i_ready = 1'b1;
        for (int i = 0; i < NV + 2; i++) begin
            if (i >= 2) begin
                check($sformatf("vec%0d_valid", i-2), {31'b0, bus.o_valid}, 32'd1);
                check($sformatf("vec%0d_data",  i-2), {16'b0, bus.o_data}, {16'b0, exp_data(vecs[i-2])});
                check($sformatf("vec%0d_ovf",   i-2), {31'b0, bus.o_ovf}, {31'b0, vecs[i-2].exp_ovf});
            end
            if (i < NV) begin
                bus.i_data  = vecs[i].din;
                bus.i_valid = 1'b1;
            end else begin
                bus.i_valid = 1'b0;
            end
            tick();
        end
        check("cnt_after_vecs",  {16'b0, ovf_cnt},  32'd5);
        check("cnt4_after_vecs", {28'b0, ovf_cnt4}, 32'd5);

        // Backpressure: stream 1..6 with the sink stalled.
        bus.i_ready = 1'b0;
        bus.i_data  = 32'd1;
        bus.i_valid = 1'b1;
        #1 check("bp_ready0", {31'b0, bus.o_ready}, 32'd1);
        tick();
        bus.i_data = 32'd2;
        #1 check("bp_ready1", {31'b0, bus.o_ready}, 32'd1);
        tick();
        bus.i_data = 32'd3;
        #1 check("bp_ready_full", {31'b0, bus.o_ready}, 32'd0);
        check("bp_head_data", {16'b0, bus.o_data}, 32'd1);
        for (int s = 0; s < 2; s++) begin
            tick();
            check("bp_stall_valid", {31'b0, bus.o_valid}, 32'd1);
            check("bp_stall_data",  {16'b0, bus.o_data},  32'd1);
            check("bp_stall_ready", {31'b0, bus.o_ready}, 32'd0);
        end
        bus.i_ready = 1'b1;
        #1 check("bp_ready_release", {31'b0, bus.o_ready}, 32'd1);
        next_in = 3;
        exp_out = 1;
        for (int c = 0; c < 20 && exp_out <= 6; c++) begin
            check("bp_no_gap", {31'b0, bus.o_valid}, 32'd1);
            xfer = bus.o_valid & bus.i_ready;
            acc  = bus.i_valid & bus.o_ready;
            if (xfer) check($sformatf("bp_out%0d", exp_out), {16'b0, bus.o_data}, exp_out);
            tick();
            if (xfer) exp_out++;
            if (acc) begin
                next_in++;
                if (next_in > 6) bus.i_valid = 1'b0;
                else bus.i_data = next_in;
            end
        end
        check("bp_all_delivered", exp_out, 32'd7);

        // Counter: clear, three overflows, clear coinciding with an overflow.
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("cnt_cleared", {16'b0, ovf_cnt}, 32'd0);
        send_stream(32'h00010000, 3);
        check("cnt_three", {16'b0, ovf_cnt}, 32'd3);
        bus.i_data  = 32'hFFFE0000;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        tick();
        check("clr_xfer_pre_valid", {31'b0, bus.o_valid}, 32'd1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("cnt_clr_with_ovf", {16'b0, ovf_cnt}, 32'd1);
        send_stream(32'h00010000, 20);
        check("cnt_21",        {16'b0, ovf_cnt},  32'd21);
        check("cnt4_saturate", {28'b0, ovf_cnt4}, 32'hF);

        // Asynchronous reset with both stages full.
        bus.i_ready = 1'b0;
        bus.i_data  = 32'h00008000;
        bus.i_valid = 1'b1;
        tick();
        bus.i_data = 32'd5;
        tick();
        bus.i_valid = 1'b0;
        check("mid_full_ready", {31'b0, bus.o_ready}, 32'd0);
        check("mid_full_ovf",   {31'b0, bus.o_ovf},   32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_o_valid", {31'b0, bus.o_valid}, 32'd0);
        check("arst_o_data",  {16'b0, bus.o_data},  32'd0);
        check("arst_o_ovf",   {31'b0, bus.o_ovf},   32'd0);
        check("arst_cnt",     {16'b0, ovf_cnt},     32'd0);
        check("arst_cnt4",    {28'b0, ovf_cnt4},    32'd0);
        check("arst_o_ready", {31'b0, bus.o_ready}, 32'd1);
        #10 rst_n = 1'b1;
        tick();
        bus.i_ready = 1'b1;
        bus.i_data  = 32'h00000042;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        check("post_rst_lat1", {31'b0, bus.o_valid}, 32'd0);
        tick();
        check("post_rst_valid", {31'b0, bus.o_valid}, 32'd1);
        check("post_rst_data",  {16'b0, bus.o_data},  32'h42);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
